fir_output_decimator: RTL and testbench

//  Downstream stage of the FIR filter. Takes the filter's wide output word each

---
 rtl/fir_pkg.sv | 41 ++++
 rtl/sample_fifo2.sv | 77 +++++++
 rtl/fir_output_decimator.sv | 108 ++++++++++
 tb/tb_fir_output_decimator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, state encoding and requantizer for the FIR output stage
//
// Purpose: default word widths, FILL/RUN state encoding and the round/saturate
// helper used by fir_output_decimator.
// Ports: none (package).
package fir_pkg;

  localparam int IN_W_DEF  = 18;
  localparam int OUT_W_DEF = 8;

  // Working width of the requantizer; any IN_W below this is zero-extended.
  localparam int MAX_W = 32;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    S_FILL = ST_FILL,
    S_RUN  = ST_RUN
  } state_t;

  // Round-half-up, shift right, clamp to out_w bits.
  // Result: bit MAX_W = saturated, bits [MAX_W-1:0] = clamped value.
  // One extra bit above the input keeps the rounding add from wrapping.
  function automatic logic [MAX_W:0] requant(input logic [MAX_W-1:0] din,
                                             input int shift,
                                             input int out_w);
    logic [MAX_W:0] one;
    logic [MAX_W:0] r;
    logic [MAX_W:0] max_v;
    one   = {{MAX_W{1'b0}}, 1'b1};
    r     = ({1'b0, din} + (one << (shift - 1))) >> shift;
    max_v = (one << out_w) - one;
    if (r > max_v) begin
      requant = {1'b1, max_v[MAX_W-1:0]};
    end else begin
      requant = {1'b0, r[MAX_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/sample_fifo2.sv
// rtl/sample_fifo2.sv - two-entry sample FIFO with a head that holds when empty
//
// Purpose: buffers requantized samples between the decimator and its consumer.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   push   in   write wdata (caller only pushes when not full, or full with pop)
//   pop    in   remove head (caller only pops when not empty)
//   wdata  in   W-bit sample to write
//   head   out  oldest entry; keeps its last value while empty (0 after reset)
//   full   out  two entries held
//   empty  out  no entries held
module sample_fifo2
  import fir_pkg::*;
#(
  parameter int W = OUT_W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem0;  // head slot
  logic [W-1:0] mem1;  // second slot
  logic [1:0]   count;

  assign head  = mem0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // Entries shift toward mem0 on pop. mem0 is only rewritten when a valid
  // value moves into it, so the head output freezes once the FIFO drains.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem0  <= '0;
      mem1  <= '0;
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            mem0  <= wdata;
            count <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b10: begin
              mem1  <= wdata;
              count <= 2'd2;
            end
            2'b01: count <= 2'd0;
            2'b11: mem0 <= wdata;
            default: ;
          endcase
        end
        2'd2: begin
          if (pop) begin
            mem0 <= mem1;
            if (push) begin
              mem1 <= wdata;
            end else begin
              count <= 2'd1;
            end
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/fir_output_decimator.sv
// rtl/fir_output_decimator.sv - fill discard, decimation, requantization and output FIFO
//
// Purpose: drops the first FILL samples after reset, keeps 1 of every DECIM
// samples, rounds/saturates them to OUT_W bits and queues them for a
// valid/ready consumer.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   Data_in    in   IN_W-bit unsigned FIR output word
//   en         in   Data_in is a new sample this cycle
//   out_data   out  FIFO head sample
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer takes the head when out_valid is also high
//   sat_flag   out  one-cycle pulse: a kept sample was saturated
//   overflow   out  sticky: a kept sample was dropped because the FIFO was full
//   clr_ovf    in   clears overflow (a same-cycle drop wins)
module fir_output_decimator
  import fir_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 8,
  parameter int DECIM = 4,
  parameter int FILL  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  Data_in,
  input  logic             en,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int FILL_W = $clog2(FILL + 1);
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t            state;
  logic [FILL_W-1:0] fill_cnt;
  logic [PH_W-1:0]   phase;

  logic             keep;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [MAX_W:0]   rq;
  logic             unused_rq;

  assign rq        = requant(MAX_W'(Data_in), SHIFT, OUT_W);
  // Bits above OUT_W of the clamped value are always zero.
  assign unused_rq = ^rq[MAX_W-1:OUT_W];

  assign keep      = en & (state == S_RUN) & (phase == '0);
  assign pop       = ~empty & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO only drops without one.
  assign drop      = keep & full & ~pop;
  assign out_valid = ~empty;

  sample_fifo2 #(.W(OUT_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (keep & ~drop),
    .pop   (pop),
    .wdata (rq[OUT_W-1:0]),
    .head  (out_data),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_FILL;
      fill_cnt <= '0;
      phase    <= '0;
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Flag saturation of every kept sample, even one that ends up dropped.
      sat_flag <= keep & rq[MAX_W];

      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end

      if (en) begin
        case (state)
          S_FILL: begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_W'(FILL - 1)) begin
              state <= S_RUN;
            end
          end
          S_RUN: begin
            phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
          end
          default: state <= S_FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_output_decimator.sv
// tb/tb_fir_output_decimator.sv - self-checking bench for fir_output_decimator
module tb_fir_output_decimator;

  localparam int IN_W  = 18;
  localparam int OUT_W = 8;
  localparam int SHIFT = 8;
  localparam int DECIM = 4;
  localparam int FILL  = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [IN_W-1:0]  Data_in = '0;
  logic             en = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             sat_flag;
  logic             overflow;
  logic             clr_ovf = 1'b0;

  int checks   = 0;
  int failures = 0;
  int sidx     = 0;

  fir_output_decimator #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(DECIM), .FILL(FILL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .Data_in   (Data_in),
    .en        (en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: counts enabled samples since reset, keeps by index, queues results.
  int         m_cnt;
  logic [7:0] m_q[$];
  logic [7:0] m_head;
  logic       m_sat;
  logic       m_ovf;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cnt  = 0;
      m_q.delete();
      m_head = 0;
      m_sat  = 0;
      m_ovf  = 0;
    end else begin
      int   r;
      int   val;
      logic kept;
      logic popped;
      popped = (m_q.size() > 0) && out_ready;
      kept   = en && (m_cnt >= FILL) && (((m_cnt - FILL) % DECIM) == 0);
      if (en) m_cnt++;
      r   = (int'(Data_in) + (1 << (SHIFT - 1))) >> SHIFT;
      val = (r > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : r;
      m_sat = kept && (r > (1 << OUT_W) - 1);
      if (popped) void'(m_q.pop_front());
      if (kept && m_q.size() >= 2) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (kept && m_q.size() < 2) m_q.push_back(val[7:0]);
      if (m_q.size() > 0) m_head = m_q[0];
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("cmp_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
      check("cmp_data", {24'd0, out_data}, {24'd0, m_head});
      check("cmp_sat", {31'd0, sat_flag}, {31'd0, m_sat});
      check("cmp_ovf", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  // Called just after a falling edge; returns after the next falling edge.
  task automatic drive(input logic [IN_W-1:0] d, input logic e, input logic rdy, input logic clr);
    Data_in   = d;
    en        = e;
    out_ready = rdy;
    clr_ovf   = clr;
    if (e) sidx++;
    @(negedge clock);
  endtask

  // Advance with non-kept samples until the next enabled sample is kept.
  task automatic align(input logic rdy);
    while (((sidx - FILL) % DECIM) != 0) drive('0, 1'b1, rdy, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    sidx  = 0;

    // 1: fill discard then decimate
    repeat (FILL) drive(18'h01234, 1'b1, 1'b1, 1'b0);
    check("t1_fill_valid", {31'd0, out_valid}, 32'd0);
    drive(18'h01234, 1'b1, 1'b1, 1'b0);
    check("t1_first_valid", {31'd0, out_valid}, 32'd1);
    check("t1_first_data", {24'd0, out_data}, 32'd18);
    drive(18'h01234, 1'b1, 1'b1, 1'b0);
    check("t1_pop_valid", {31'd0, out_valid}, 32'd0);
    check("t1_hold_data", {24'd0, out_data}, 32'd18);
    repeat (2) drive(18'h01234, 1'b1, 1'b1, 1'b0);
    drive(18'h01234, 1'b1, 1'b1, 1'b0);
    check("t1_second_valid", {31'd0, out_valid}, 32'd1);

    // 2: rounding boundary
    align(1'b1);
    drive(18'h00180, 1'b1, 1'b1, 1'b0);
    check("t2_round_up", {24'd0, out_data}, 32'd2);
    check("t2_sat0", {31'd0, sat_flag}, 32'd0);
    align(1'b1);
    drive(18'h0017F, 1'b1, 1'b1, 1'b0);
    check("t2_round_dn", {24'd0, out_data}, 32'd1);

    // 3: saturation pulse
    align(1'b1);
    drive(18'h3FFFF, 1'b1, 1'b1, 1'b0);
    check("t3_sat_data", {24'd0, out_data}, 32'd255);
    check("t3_sat_hi", {31'd0, sat_flag}, 32'd1);
    drive('0, 1'b1, 1'b1, 1'b0);
    check("t3_sat_lo", {31'd0, sat_flag}, 32'd0);

    // 4: backpressure, drop, drain, clear
    align(1'b0);
    drive(18'h00A00, 1'b1, 1'b0, 1'b0);
    align(1'b0);
    drive(18'h01400, 1'b1, 1'b0, 1'b0);
    align(1'b0);
    drive(18'h01E00, 1'b1, 1'b0, 1'b0);
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    check("t4_head10", {24'd0, out_data}, 32'd10);
    drive('0, 1'b1, 1'b1, 1'b0);
    check("t4_head20", {24'd0, out_data}, 32'd20);
    drive('0, 1'b1, 1'b1, 1'b0);
    check("t4_empty", {31'd0, out_valid}, 32'd0);
    drive('0, 1'b1, 1'b1, 1'b1);
    check("t4_clr", {31'd0, overflow}, 32'd0);

    // 5: full FIFO with pop and push on the same edge
    align(1'b0);
    drive(18'h00500, 1'b1, 1'b0, 1'b0);
    align(1'b0);
    drive(18'h00600, 1'b1, 1'b0, 1'b0);
    align(1'b0);
    drive(18'h00700, 1'b1, 1'b1, 1'b0);
    check("t5_no_ovf", {31'd0, overflow}, 32'd0);
    check("t5_head6", {24'd0, out_data}, 32'd6);
    drive('0, 1'b1, 1'b1, 1'b0);
    check("t5_head7", {24'd0, out_data}, 32'd7);
    drive('0, 1'b1, 1'b1, 1'b0);
    check("t5_empty", {31'd0, out_valid}, 32'd0);

    // drop and clear on the same edge: set wins
    align(1'b0);
    drive(18'h00100, 1'b1, 1'b0, 1'b0);
    align(1'b0);
    drive(18'h00200, 1'b1, 1'b0, 1'b0);
    align(1'b0);
    drive(18'h00300, 1'b1, 1'b0, 1'b1);
    check("t5_set_wins", {31'd0, overflow}, 32'd1);
    drive('0, 1'b1, 1'b1, 1'b0);
    drive('0, 1'b1, 1'b1, 1'b0);
    drive('0, 1'b1, 1'b1, 1'b1);
    check("t5_clr2", {31'd0, overflow}, 32'd0);

    // 6: asynchronous reset mid-RUN with a full FIFO
    align(1'b0);
    drive(18'h00900, 1'b1, 1'b0, 1'b0);
    align(1'b0);
    drive(18'h00A00, 1'b1, 1'b0, 1'b0);
    check("t6_full", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, out_valid}, 32'd0);
    check("t6_async_data", {24'd0, out_data}, 32'd0);
    check("t6_async_ovf", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    sidx  = 0;
    repeat (8) drive(18'h01234, 1'b1, 1'b1, 1'b0);
    repeat (5) drive(18'h01234, 1'b0, 1'b1, 1'b0);
    repeat (8) drive(18'h01234, 1'b1, 1'b1, 1'b0);
    check("t6_refill_valid", {31'd0, out_valid}, 32'd0);
    drive(18'h01234, 1'b1, 1'b1, 1'b0);
    check("t6_first_valid", {31'd0, out_valid}, 32'd1);
    check("t6_first_data", {24'd0, out_data}, 32'd18);
    repeat (3) drive(18'h01234, 1'b0, 1'b1, 1'b0);
    repeat (3) drive(18'h01234, 1'b1, 1'b1, 1'b0);
    check("t6_pause_valid", {31'd0, out_valid}, 32'd0);
    drive(18'h00280, 1'b1, 1'b1, 1'b0);
    check("t6_phase_valid", {31'd0, out_valid}, 32'd1);
    check("t6_phase_data", {24'd0, out_data}, 32'd3);
    drive('0, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
